// File: rtl/vpc_control_unit_if.sv
// vpc_control_unit_if: control/flag inputs (start, stall, FlagsWrite, Id, ALUFlags, Imm) and status outputs (PCNext, EndFlag, COMFlag, RasErr)
interface vpc_control_unit_if #(
  parameter int PC_W  = 32,
  parameter int LANES = 6,
  parameter int IMM_W = 18
);
  logic               start;
  logic               stall;
  logic               FlagsWrite;
  logic [3:0]         Id;
  logic [2*LANES-1:0] ALUFlags;
  logic [IMM_W-1:0]   Imm;
  logic [PC_W-1:0]    PCNext;
  logic               EndFlag;
  logic               COMFlag;
  logic               RasErr;
  modport master (output start, stall, FlagsWrite, Id, ALUFlags, Imm, input PCNext, EndFlag, COMFlag, RasErr);
  modport slave  (input start, stall, FlagsWrite, Id, ALUFlags, Imm, output PCNext, EndFlag, COMFlag, RasErr);
endinterface

// File: rtl/vpc_control_unit.sv
// vpc_control_unit: vector PC sequencer (clk, async reset, bus: start/stall/FlagsWrite/Id/ALUFlags/Imm in, PCNext/EndFlag/COMFlag/RasErr out) with lane-reduced branches and a circular return-address stack
module vpc_control_unit #(
  parameter int PC_W      = 32,
  parameter int LANES     = 6,
  parameter int IMM_W     = 18,
  parameter int RAS_DEPTH = 4,
  parameter int COND_ANY  = 0
) (
  input logic clk,
  input logic reset,
  vpc_control_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2;
  localparam int AW = $clog2(RAS_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(RAS_DEPTH);
  logic [1:0] state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, tgt;
  logic com_q, com_d, err_q, err_d, push, go, full, empty, cond_z, cond_n;
  logic [2*LANES-1:0] flag_q, flags;
  logic [LANES-1:0] z, n;
  logic [PC_W-1:0] ras_q [RAS_DEPTH];
  logic [AW-1:0] sp_q, sp_d, sp_prev;
  logic [AW:0] cnt_q, cnt_d;
  assign pc_inc  = pc_q + PC_W'(4);
  assign tgt     = PC_W'(bus.Imm);
  assign go      = state_q == RUN && !bus.stall;
  assign full    = cnt_q == FULL;
  assign empty   = cnt_q == '0;
  assign sp_prev = sp_q - 1'b1;
  assign flags   = bus.FlagsWrite ? bus.ALUFlags : flag_q;
  always_comb begin
    z = '0;
    n = '0;
    for (int i = 0; i < LANES; i++) begin
      z[i] = flags[2*i];
      n[i] = flags[2*i+1];
    end
  end
  assign cond_z = COND_ANY != 0 ? |z : &z;
  assign cond_n = COND_ANY != 0 ? |n : &n;
  always_comb begin
    state_d = state_q == IDLE && bus.start ? RUN : state_q;
    pc_d    = pc_q;
    com_d   = 1'b0;
    err_d   = err_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (go) begin
      case (bus.Id)
        4'hC: begin
          pc_d  = tgt;
          com_d = 1'b1;
        end
        4'hD: begin
          pc_d  = cond_z ? tgt : pc_inc;
          com_d = cond_z;
        end
        4'hE: begin
          pc_d  = cond_n ? tgt : pc_inc;
          com_d = cond_n;
        end
        4'h8: begin
          push  = 1'b1;
          pc_d  = tgt;
          com_d = 1'b1;
          sp_d  = sp_q + 1'b1;
          cnt_d = full ? cnt_q : cnt_q + 1'b1;
          err_d = err_q | full;
        end
        4'h9: begin
          pc_d  = empty ? pc_inc : ras_q[sp_prev];
          com_d = !empty;
          err_d = err_q | empty;
          sp_d  = empty ? sp_q : sp_prev;
          cnt_d = empty ? cnt_q : cnt_q - 1'b1;
        end
        4'hF: state_d = HALT;
        default: pc_d = pc_inc;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      com_q   <= 1'b0;
      err_q   <= 1'b0;
      flag_q  <= '0;
      sp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      com_q   <= com_d;
      err_q   <= err_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      if (bus.FlagsWrite) flag_q <= bus.ALUFlags;
    end
  end
  always_ff @(posedge clk) if (push) ras_q[sp_q] <= pc_inc;
  assign bus.PCNext  = pc_q;
  assign bus.EndFlag = state_q == HALT;
  assign bus.COMFlag = com_q;
  assign bus.RasErr  = err_q;
endmodule

// File: tb/tb_vpc_control_unit.sv
// tb_vpc_control_unit: directed checks of sequencing, branches, lane reduction, RAS and reset on AND/OR reduction variants
module tb_vpc_control_unit;
  logic clk, reset;
  int checks = 0, errors = 0;
  vpc_control_unit_if #(.PC_W(32), .LANES(6), .IMM_W(18)) if0 ();
  vpc_control_unit_if #(.PC_W(32), .LANES(6), .IMM_W(18)) if1 ();
  vpc_control_unit #(.COND_ANY(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  vpc_control_unit #(.COND_ANY(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  assign if1.start      = if0.start;
  assign if1.stall      = if0.stall;
  assign if1.FlagsWrite = if0.FlagsWrite;
  assign if1.Id         = if0.Id;
  assign if1.ALUFlags   = if0.ALUFlags;
  assign if1.Imm        = if0.Imm;
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic [3:0] id, input logic [17:0] imm);
    if0.Id = id;
    if0.Imm = imm;
    cyc();
  endtask
  task automatic restart();
    reset = 1;
    #2;
    reset = 0;
    if0.start = 1;
    op(4'h6, 18'h0);
    if0.start = 0;
  endtask
  logic [31:0] call_pc [5] = '{32'h4, 32'h104, 32'h204, 32'h304, 32'h404};
  initial begin
    reset = 1;
    if0.start = 0;
    if0.stall = 0;
    if0.FlagsWrite = 0;
    if0.Id = 4'h6;
    if0.ALUFlags = '0;
    if0.Imm = '0;
    cyc();
    chk("rst_pc", if0.PCNext, 32'h0);
    chk("rst_end", {31'b0, if0.EndFlag}, 32'h0);
    chk("rst_com", {31'b0, if0.COMFlag}, 32'h0);
    chk("rst_err", {31'b0, if0.RasErr}, 32'h0);
    op(4'h6, 18'h0);
    chk("idle_hold", if0.PCNext, 32'h0);
    reset = 0;
    if0.start = 1;
    op(4'h6, 18'h0);
    chk("start_pc", if0.PCNext, 32'h0);
    if0.start = 0;
    for (int i = 1; i <= 3; i++) begin
      op(4'h6, 18'h0);
      chk("seq_pc", if0.PCNext, 32'(4 * i));
      chk("seq_com", {31'b0, if0.COMFlag}, 32'h0);
    end
    op(4'hC, 18'h50);
    chk("jmp_pc", if0.PCNext, 32'h50);
    chk("jmp_com", {31'b0, if0.COMFlag}, 32'h1);
    op(4'h6, 18'h0);
    chk("after_jmp_pc", if0.PCNext, 32'h54);
    chk("after_jmp_com", {31'b0, if0.COMFlag}, 32'h0);
    if0.FlagsWrite = 1;
    if0.ALUFlags = 12'h555;
    op(4'hD, 18'h13C);
    chk("jeq_all_and", if0.PCNext, 32'h13C);
    chk("jeq_all_or", if1.PCNext, 32'h13C);
    chk("jeq_all_com", {31'b0, if0.COMFlag}, 32'h1);
    if0.ALUFlags = 12'h554;
    op(4'hD, 18'h13C);
    chk("jeq_one_and", if0.PCNext, 32'h140);
    chk("jeq_one_and_com", {31'b0, if0.COMFlag}, 32'h0);
    chk("jeq_one_or", if1.PCNext, 32'h13C);
    if0.FlagsWrite = 0;
    if0.ALUFlags = '0;
    op(4'hD, 18'h13C);
    chk("jeq_reg_and", if0.PCNext, 32'h144);
    chk("jeq_reg_or", if1.PCNext, 32'h13C);
    if0.FlagsWrite = 1;
    if0.ALUFlags = 12'hAAA;
    op(4'hE, 18'h10);
    chk("jlt_and", if0.PCNext, 32'h10);
    chk("jlt_or", if1.PCNext, 32'h10);
    if0.FlagsWrite = 0;
    op(4'h8, 18'h94);
    chk("call_pc", if0.PCNext, 32'h94);
    chk("call_com", {31'b0, if0.COMFlag}, 32'h1);
    op(4'h9, 18'h0);
    chk("ret_pc", if0.PCNext, 32'h14);
    chk("ret_com", {31'b0, if0.COMFlag}, 32'h1);
    chk("ret_err", {31'b0, if0.RasErr}, 32'h0);
    op(4'h9, 18'h0);
    chk("ret_empty_pc", if0.PCNext, 32'h18);
    chk("ret_empty_err", {31'b0, if0.RasErr}, 32'h1);
    chk("ret_empty_com", {31'b0, if0.COMFlag}, 32'h0);
    restart();
    chk("restart_pc", if0.PCNext, 32'h0);
    chk("restart_err", {31'b0, if0.RasErr}, 32'h0);
    for (int i = 1; i <= 5; i++) begin
      op(4'h8, 18'(i * 32'h100));
      chk("ovf_call_pc", if0.PCNext, 32'(i * 32'h100));
      chk("ovf_call_err", {31'b0, if0.RasErr}, {31'b0, i == 5});
    end
    for (int i = 4; i >= 1; i--) begin
      op(4'h9, 18'h0);
      chk("ovf_ret_pc", if0.PCNext, call_pc[i]);
    end
    op(4'h9, 18'h0);
    chk("ovf_ret_last_pc", if0.PCNext, 32'h108);
    chk("ovf_ret_last_com", {31'b0, if0.COMFlag}, 32'h0);
    chk("ovf_err_sticky", {31'b0, if0.RasErr}, 32'h1);
    if0.stall = 1;
    op(4'hC, 18'h40);
    chk("stall_pc", if0.PCNext, 32'h108);
    chk("stall_com", {31'b0, if0.COMFlag}, 32'h0);
    if0.stall = 0;
    op(4'hC, 18'h40);
    chk("unstall_pc", if0.PCNext, 32'h40);
    op(4'hF, 18'h0);
    chk("end_flag", {31'b0, if0.EndFlag}, 32'h1);
    chk("end_pc", if0.PCNext, 32'h40);
    if0.start = 1;
    op(4'hC, 18'h80);
    if0.start = 0;
    chk("halt_pc", if0.PCNext, 32'h40);
    chk("halt_end", {31'b0, if0.EndFlag}, 32'h1);
    reset = 1;
    #2;
    chk("halt_rst_end", {31'b0, if0.EndFlag}, 32'h0);
    chk("halt_rst_err", {31'b0, if0.RasErr}, 32'h0);
    restart();
    op(4'h6, 18'h0);
    op(4'h6, 18'h0);
    chk("pre_rst_pc", if0.PCNext, 32'h8);
    #2;
    reset = 1;
    #1;
    chk("async_rst_pc", if0.PCNext, 32'h0);
    reset = 0;
    op(4'h6, 18'h0);
    op(4'h6, 18'h0);
    chk("idle_after_rst", if0.PCNext, 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vpc_control_unit.md
VPC_CONTROL_UNIT -- requirements
Module: vpc_control_unit

Interface
REQ-001 SHALL take parameter PC_W, default 32, PC width in bits.
REQ-002 SHALL take parameter LANES, default 6, number of vector lanes supplying flags.
REQ-003 SHALL take parameter IMM_W, default 18, branch-immediate width (IMM_W <= PC_W).
REQ-004 SHALL take parameter RAS_DEPTH, default 4, return-address-stack entries (power of 2).
REQ-005 SHALL take parameter COND_ANY, default 0, lane reduction (0 = all lanes, 1 = any lane).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have ports: start input 1 (begin execution); stall input 1 (freeze sequencing); FlagsWrite input 1 (capture flags); Id input 4 (opcode).
REQ-009 SHALL have ports: ALUFlags input LANES x 2 (per lane: bit0 = Z, bit1 = N); Imm input IMM_W (absolute byte target).
REQ-010 SHALL have ports: PCNext output PC_W (registered PC); EndFlag output 1 (halted); COMFlag output 1 (taken-redirect pulse); RasErr output 1 (sticky stack error).

Function
REQ-011 SHALL implement states IDLE, RUN, HALT: IDLE->RUN on start=1; RUN->HALT on Id=F when not stalled; HALT exited only by reset; start ignored outside IDLE.
REQ-012 SHALL hold PCNext in IDLE; the IDLE->RUN edge leaves PCNext unchanged (first fetch at 0).
REQ-013 SHALL, in RUN with stall=0, update PCNext every clock per Id; stall=1 freezes PCNext, state, RAS, COMFlag=0.
REQ-014 SHALL decode Id: C JMP, D JEQ, E JLT, 8 CALL, 9 RET, F END; all others sequential (PC+4).
REQ-015 SHALL form branch targets as Imm zero-extended to PC_W; PC+4 wraps modulo 2^PC_W.
REQ-016 SHALL capture ALUFlags into a flag register on any clock with FlagsWrite=1, regardless of state or stall.
REQ-017 SHALL evaluate conditions on ALUFlags when FlagsWrite=1 in the same cycle (bypass), else on the flag register.
REQ-018 SHALL reduce per-lane Z (JEQ) or N (JLT) by AND over lanes when COND_ANY=0, OR when COND_ANY=1.
REQ-019 SHALL set PCNext to target if JMP, or JEQ/JLT with condition true; otherwise PC+4.
REQ-020 SHALL pulse COMFlag for exactly the cycle after each taken JMP/JEQ/JLT/CALL/RET update; 0 otherwise.
REQ-021 SHALL, on CALL, push PC+4 and load target; when full, overwrite oldest entry, keep count at RAS_DEPTH, set RasErr.
REQ-022 SHALL, on RET, pop into PCNext; when empty, load PC+4, set RasErr, no COMFlag.
REQ-023 SHALL, on END, keep PCNext unchanged and set EndFlag=1, held in HALT.
REQ-024 SHALL keep RasErr sticky until reset.

Reset
REQ-025 SHALL, on reset asserted at any time, immediately force IDLE, PCNext=0, EndFlag=0, COMFlag=0, RasErr=0, flag register=0, RAS empty.
REQ-026 SHALL resume only via start after reset deassertion; mid-operation reset discards all in-flight state.

Verification
REQ-027 Reset, start=1, Id=6 x3 -> PCNext 0,4,8,C; COMFlag=0 throughout.
REQ-028 Id=C, Imm=0x50 -> PCNext=0x50, COMFlag=1 next cycle.
REQ-029 COND_ANY=0, FlagsWrite=1, all lanes Z=1, Id=D, Imm=0x13C -> PCNext=0x13C; repeat with one lane Z=0 -> PC+4; with COND_ANY=1 the same repeat -> 0x13C.
REQ-030 PC=0x10, CALL Imm=0x94 -> PCNext=0x94; RET -> PCNext=0x14; RET on empty -> PC+4, RasErr=1.
REQ-031 RAS_DEPTH+1 CALLs then RAS_DEPTH+1 RETs -> RasErr=1, last RET falls through to PC+4, earlier RETs return newest-first.
REQ-032 stall=1 during JMP -> PCNext frozen; Id=F -> EndFlag=1 held; reset mid-RUN -> PCNext=0 asynchronously, EndFlag=0.
